// File: rtl/calc_input_sequencer_if.sv
// calc_input_sequencer_if
//   Bundles the keypad strobes, the ALU operand/result connection and the
//   display/status outputs of the calculator input sequencer.
//   master : keypad/ALU side (drives strobes and alu_y, observes the rest)
//   slave  : the sequencer itself
//   Signals: digit_valid/digit, op_valid/op_sel, eq_valid, clr, alu_y,
//            alu_a, alu_b, alu_op, disp_val, result_valid, err
interface calc_input_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             op_valid;
  logic [3:0]       op_sel;
  logic             eq_valid;
  logic             clr;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] disp_val;
  logic             result_valid;
  logic             err;

  modport master (
    output digit_valid, digit, op_valid, op_sel, eq_valid, clr, alu_y,
    input  alu_a, alu_b, alu_op, disp_val, result_valid, err
  );

  modport slave (
    input  digit_valid, digit, op_valid, op_sel, eq_valid, clr, alu_y,
    output alu_a, alu_b, alu_op, disp_val, result_valid, err
  );
endinterface

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer
//   Accumulates decimal keypad digits into operands A and B, latches a
//   one-hot opcode, drives the combinational ALU and commits its result on
//   equals. Supports operator chaining and traps divide-by-zero.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : keypad strobes + alu_y in; alu_a/alu_b/alu_op, disp_val,
//            result_valid, err out
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ENTER_A | entering first operand (or after clear)
//   OP_WAIT | operator latched, waiting for first B digit
//   ENTER_B | entering second operand
//   RESULT  | result committed and displayed
//   ERROR   | divide-by-zero trapped; only clr leaves
module calc_input_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 9
) (
  input logic                    clk,
  input logic                    rst_n,
  calc_input_sequencer_if.slave  bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTER_B = 3'd2,
    RESULT  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;

  logic             op_ok, digit_bcd, digit_ok, div_zero;
  logic             do_eq, do_op, do_digit;
  logic [WIDTH-1:0] acc_src, acc_val;
  logic [CW-1:0]    acc_cnt;

  // x*10 + d built from shifts; MAX_DIGITS keeps this inside WIDTH
  function automatic logic [WIDTH-1:0] times_ten_plus(input logic [WIDTH-1:0] x,
                                                      input logic [3:0] d);
    return (x << 3) + (x << 1) + WIDTH'(d);
  endfunction

  assign op_ok     = (bus.op_sel == 4'b0001) || (bus.op_sel == 4'b0010) ||
                     (bus.op_sel == 4'b0100) || (bus.op_sel == 4'b1000);
  assign digit_bcd = (bus.digit <= 4'd9);
  assign digit_ok  = digit_bcd && (cnt_q != CW'(MAX_DIGITS));
  assign div_zero  = (op_q == 4'b1000) && (b_q == '0);

  // Only the highest-priority strobe present acts, even if the state ignores it
  assign do_eq    = !bus.clr && bus.eq_valid;
  assign do_op    = !bus.clr && !bus.eq_valid && bus.op_valid && op_ok;
  assign do_digit = !bus.clr && !bus.eq_valid && !bus.op_valid && bus.digit_valid;

  always_comb begin
    acc_src = (state_q == ENTER_A) ? a_q : b_q;
    acc_val = acc_src;
    acc_cnt = cnt_q;
    // a leading zero neither changes the value nor uses up a digit slot
    if (!(cnt_q == '0 && bus.digit == 4'd0)) begin
      acc_val = times_ten_plus(acc_src, bus.digit);
      acc_cnt = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    if (bus.clr) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      op_d    = 4'b0000;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (do_op) begin
            op_d    = bus.op_sel;
            b_d     = '0;
            cnt_d   = '0;
            state_d = OP_WAIT;
          end else if (do_digit && digit_ok) begin
            a_d   = acc_val;
            cnt_d = acc_cnt;
          end
        end
        OP_WAIT: begin
          if (do_op) begin
            op_d = bus.op_sel;
          end else if (do_digit && digit_ok) begin
            b_d     = acc_val;
            cnt_d   = acc_cnt;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (do_eq || do_op) begin
            if (div_zero) begin
              state_d = ERROR;
            end else if (do_eq) begin
              res_d   = bus.alu_y;
              a_d     = bus.alu_y;
              rv_d    = 1'b1;
              state_d = RESULT;
            end else begin
              a_d     = bus.alu_y;
              op_d    = bus.op_sel;
              b_d     = '0;
              cnt_d   = '0;
              state_d = OP_WAIT;
            end
          end else if (do_digit && digit_ok) begin
            b_d   = acc_val;
            cnt_d = acc_cnt;
          end
        end
        RESULT: begin
          if (do_op) begin
            op_d    = bus.op_sel;
            b_d     = '0;
            cnt_d   = '0;
            state_d = OP_WAIT;
          end else if (do_digit && digit_bcd) begin
            a_d     = WIDTH'(bus.digit);
            cnt_d   = (bus.digit == 4'd0) ? CW'(0) : CW'(1);
            b_d     = '0;
            op_d    = 4'b0000;
            state_d = ENTER_A;
          end
        end
        ERROR: begin
        end
        default: state_d = ENTER_A;
      endcase
    end

    case (state_d)
      ENTER_A, OP_WAIT: disp_d = a_d;
      ENTER_B:          disp_d = b_d;
      RESULT:           disp_d = res_d;
      default:          disp_d = '0;
    endcase
    err_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      op_q    <= 4'b0000;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_op       = op_q;
  assign bus.disp_val     = disp_q;
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
module tb_calc_input_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  calc_input_sequencer_if #(.WIDTH(32)) bus();

  calc_input_sequencer #(.WIDTH(32), .MAX_DIGITS(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0100: return 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
      4'b1000: return (b == 0) ? 32'd0 : a / b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_y = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  // ---------------- behavioural calculator model ----------------
  localparam int M_A = 0, M_OPW = 1, M_B = 2, M_RES = 3, M_ERR = 4;
  int          m_mode;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  int          m_ndig;
  logic        m_rv;

  function automatic bit is_onehot(input logic [3:0] v);
    return (v == 4'd1) || (v == 4'd2) || (v == 4'd4) || (v == 4'd8);
  endfunction

  task automatic model_clear();
    m_mode = M_A; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_ndig = 0; m_rv = 0;
  endtask

  task automatic push_digit(inout logic [31:0] x, input int d);
    if (m_ndig < 9 && !(m_ndig == 0 && d == 0)) begin
      x = x * 10 + 32'(d);
      m_ndig++;
    end
  endtask

  task automatic commit(input bit is_eq, input logic [3:0] os);
    logic [31:0] y;
    if (m_op == 4'b1000 && m_b == 0) begin
      m_mode = M_ERR;
    end else begin
      y = alu_ref(m_a, m_b, m_op);
      m_a = y;
      if (is_eq) begin
        m_res = y; m_rv = 1; m_mode = M_RES;
      end else begin
        m_op = os; m_b = 0; m_ndig = 0; m_mode = M_OPW;
      end
    end
  endtask

  task automatic model_step(input logic dv, input logic [3:0] d, input logic ov,
                            input logic [3:0] os, input logic ev, input logic c);
    m_rv = 0;
    if (c) model_clear();
    else if (m_mode == M_ERR) begin end
    else if (ev) begin
      if (m_mode == M_B) commit(1, os);
    end else if (ov) begin
      if (is_onehot(os)) begin
        if (m_mode == M_B) commit(0, os);
        else begin
          m_op = os;
          if (m_mode != M_OPW) begin m_b = 0; m_ndig = 0; m_mode = M_OPW; end
        end
      end
    end else if (dv && d <= 9) begin
      case (m_mode)
        M_A:   push_digit(m_a, int'(d));
        M_OPW: begin m_b = 0; m_ndig = 0; push_digit(m_b, int'(d)); m_mode = M_B; end
        M_B:   push_digit(m_b, int'(d));
        M_RES: begin
          m_a = 32'(d); m_ndig = (d != 0) ? 1 : 0; m_b = 0; m_op = 0; m_mode = M_A;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_disp();
    case (m_mode)
      M_A, M_OPW: return m_a;
      M_B:        return m_b;
      M_RES:      return m_res;
      default:    return 32'd0;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [3:0] eop, input logic [31:0] ed,
                         input logic erv, input logic eer);
    cmp({nm, ".alu_a"},        bus.alu_a, ea);
    cmp({nm, ".alu_b"},        bus.alu_b, eb);
    cmp({nm, ".alu_op"},       32'(bus.alu_op), 32'(eop));
    cmp({nm, ".disp_val"},     bus.disp_val, ed);
    cmp({nm, ".result_valid"}, 32'(bus.result_valid), 32'(erv));
    cmp({nm, ".err"},          32'(bus.err), 32'(eer));
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic ov,
                       input logic [3:0] os, input logic ev, input logic c);
    @(negedge clk);
    bus.digit_valid = dv; bus.digit = d;
    bus.op_valid = ov; bus.op_sel = os;
    bus.eq_valid = ev; bus.clr = c;
    @(posedge clk);
    #1;
    bus.digit_valid = 0; bus.op_valid = 0; bus.eq_valid = 0; bus.clr = 0;
    model_step(dv, d, ov, os, ev, c);
  endtask

  task automatic key(input int d);
    drive(1, 4'(d), 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic dv; logic [3:0] d; logic ov; logic [3:0] os; logic ev; logic c;
    logic [31:0] ea; logic [31:0] eb; logic [3:0] eop; logic [31:0] ed;
    logic erv; logic eer;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(int dv, int d, int ov, int os, int ev, int c,
                               int ea, int eb, int eop, int ed, int erv, int eer);
    vec_t v;
    v.dv = 1'(dv); v.d = 4'(d); v.ov = 1'(ov); v.os = 4'(os); v.ev = 1'(ev); v.c = 1'(c);
    v.ea = 32'(ea); v.eb = 32'(eb); v.eop = 4'(eop); v.ed = 32'(ed);
    v.erv = 1'(erv); v.eer = 1'(eer);
    return v;
  endfunction

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.digit_valid = 0; bus.digit = 0; bus.op_valid = 0; bus.op_sel = 0;
    bus.eq_valid = 0; bus.clr = 0;
    model_clear();

    //         dv d  ov os ev c    a          b   op disp      rv err
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,  0,         0,  0, 0,         0, 0));
    // 1 2 (bad op) (digit 12) + 3 4 = ; eq in RESULT ignored
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0,  1,         0,  0, 1,         0, 0));
    vecs.push_back(mkv(1, 2, 0, 0, 0, 0,  12,        0,  0, 12,        0, 0));
    vecs.push_back(mkv(0, 0, 1, 3, 0, 0,  12,        0,  0, 12,        0, 0));
    vecs.push_back(mkv(1, 12, 0, 0, 0, 0, 12,        0,  0, 12,        0, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0,  12,        0,  1, 12,        0, 0));
    vecs.push_back(mkv(1, 3, 0, 0, 0, 0,  12,        3,  1, 3,         0, 0));
    vecs.push_back(mkv(1, 4, 0, 0, 0, 0,  12,        34, 1, 34,        0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0,  46,        34, 1, 46,        1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  46,        34, 1, 46,        0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0,  46,        34, 1, 46,        0, 0));
    // 9 * 9 - 1 = (digit in RESULT starts fresh)
    vecs.push_back(mkv(1, 9, 0, 0, 0, 0,  9,         0,  0, 9,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 4, 0, 0,  9,         0,  4, 9,         0, 0));
    vecs.push_back(mkv(1, 9, 0, 0, 0, 0,  9,         9,  4, 9,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 2, 0, 0,  81,        0,  2, 81,        0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0,  81,        1,  2, 1,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0,  80,        1,  2, 80,        1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  80,        1,  2, 80,        0, 0));
    // 8 / 0 = -> trap; 5 and + ignored; clr recovers
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,  0,         0,  0, 0,         0, 0));
    vecs.push_back(mkv(1, 8, 0, 0, 0, 0,  8,         0,  0, 8,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 8, 0, 0,  8,         0,  8, 8,         0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0,  8,         0,  8, 0,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0,  8,         0,  8, 0,         0, 1));
    vecs.push_back(mkv(1, 5, 0, 0, 0, 0,  8,         0,  8, 0,         0, 1));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0,  8,         0,  8, 0,         0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,  0,         0,  0, 0,         0, 0));
    // 5 + - 2 = -> 3 ; then clr and eq together in ENTER_B
    vecs.push_back(mkv(1, 5, 0, 0, 0, 0,  5,         0,  0, 5,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0,  5,         0,  1, 5,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 2, 0, 0,  5,         0,  2, 5,         0, 0));
    vecs.push_back(mkv(1, 2, 0, 0, 0, 0,  5,         2,  2, 2,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0,  3,         2,  2, 3,         1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  3,         2,  2, 3,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1,  0,         0,  0, 0,         0, 0));
    vecs.push_back(mkv(1, 5, 0, 0, 0, 0,  5,         0,  0, 5,         0, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0,  5,         0,  1, 5,         0, 0));
    vecs.push_back(mkv(1, 2, 0, 0, 0, 0,  5,         2,  1, 2,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 1,  0,         0,  0, 0,         0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0,  0,         0,  0, 0,         0, 0));

    // ---- reset behaviour, including reset in the middle of entry ----
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    key(1);
    key(2);
    cmp_all("pre_rst", 12, 0, 0, 12, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cmp_all("mid_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    key(3);
    cmp_all("post_rst", 3, 0, 0, 3, 0, 0);

    // ---- table ----
    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].d, vecs[i].ov, vecs[i].os, vecs[i].ev, vecs[i].c);
      cmp_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop,
              vecs[i].ed, vecs[i].erv, vecs[i].eer);
    end

    // ---- digit limit and leading zeros ----
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) key(9);
    key(12);
    cmp_all("max_digits", 999999999, 0, 0, 999999999, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    key(0); key(0); key(7);
    cmp_all("lead_zero", 7, 0, 0, 7, 0, 0);
    for (int i = 0; i < 9; i++) key(1);
    cmp_all("lead_zero_cnt", 711111111, 0, 0, 711111111, 0, 0);

    // ---- randomized run against the model ----
    drive(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] os;
      r  = int'($urandom_range(0, 99));
      os = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'(4'b0001 << $urandom_range(0, 3));
      if (r < 3)       drive(0, 0, 0, 0, 0, 1);
      else if (r < 18) drive(0, 0, 0, 0, 1, 0);
      else if (r < 38) drive(0, 0, 1, os, 0, 0);
      else if (r < 90) drive(1, 4'($urandom_range(0, 11)), 0, 0, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0);
      cmp_all($sformatf("rnd%0d", n), m_a, m_b, m_op, m_disp(), m_rv,
              (m_mode == M_ERR) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
